// File: rtl/stat_sched_if.sv
// Debug read channel of stat_sched: request/select from the requester,
// one-cycle acknowledge with data back from the scheduler.
interface stat_sched_if;
   logic        in_RDREQ;
   logic [1:0]  in_RDSEL;
   logic        out_RDACK;
   logic [31:0] out_RDDATA;

   modport master (
      output in_RDREQ,
      output in_RDSEL,
      input  out_RDACK,
      input  out_RDDATA
   );

   modport slave (
      input  in_RDREQ,
      input  in_RDSEL,
      output out_RDACK,
      output out_RDDATA
   );
endinterface

// File: rtl/stat_sched.sv
// Performance-counter display/readout scheduler: live display while running,
// snapshot and round-robin scan while halted, two-cycle counter clear.
module stat_sched #(
   parameter int unsigned DWELL = 4
) (
   input  logic        in_CLK,
   input  logic        in_RST,
   input  logic        in_HALT,
   input  logic        in_CLRREQ,
   input  logic [31:0] in_total,
   input  logic [31:0] in_J,
   input  logic [31:0] in_JS,
   input  logic [31:0] in_loaduse,
   input  logic        in_RDREQ,
   input  logic [1:0]  in_RDSEL,
   output logic        out_RDACK,
   output logic [31:0] out_RDDATA,
   output logic [31:0] out_DISP,
   output logic [1:0]  out_DISPSEL,
   output logic        out_CNTRST,
   output logic [1:0]  out_STATE
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_SNAP  = 2'd1,
      ST_SCAN  = 2'd2,
      ST_CLEAR = 2'd3
   } state_e;

   localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

   state_e      state_q, state_d;
   logic        clr_phase_q, clr_phase_d;
   logic [31:0] live [4];
   logic [31:0] snap_q [4];
   logic [31:0] snap_d [4];
   logic [15:0] dwell_q, dwell_d;
   logic [1:0]  sel_q, sel_d;
   logic [31:0] disp_q, disp_d;
   logic        cntrst_q, cntrst_d;
   logic        pend_q, pend_d;
   logic        ack_q, ack_d;
   logic [31:0] rddata_q, rddata_d;

   always_comb begin
      live[0] = in_total;
      live[1] = in_J;
      live[2] = in_JS;
      live[3] = in_loaduse;
   end

   // CLEAR runs two fixed cycles and ignores CLRREQ; elsewhere CLRREQ beats HALT.
   always_comb begin
      state_d     = state_q;
      clr_phase_d = 1'b0;
      if (state_q == ST_CLEAR) begin
         if (clr_phase_q) begin
            state_d = ST_RUN;
         end else begin
            clr_phase_d = 1'b1;
         end
      end else if (in_CLRREQ) begin
         state_d = ST_CLEAR;
      end else begin
         case (state_q)
            ST_RUN:  if (in_HALT) state_d = ST_SNAP;
            ST_SNAP: state_d = ST_SCAN;
            ST_SCAN: if (!in_HALT) state_d = ST_RUN;
            default: state_d = ST_RUN;
         endcase
      end
   end

   // Display registers are loaded for the state being entered, so they
   // always describe the current cycle's state.
   always_comb begin
      snap_d   = snap_q;
      dwell_d  = dwell_q;
      sel_d    = sel_q;
      disp_d   = disp_q;
      cntrst_d = (state_d == ST_CLEAR);
      case (state_d)
         ST_RUN: begin
            sel_d  = 2'd0;
            disp_d = in_total;
         end
         ST_SNAP: begin
            snap_d  = live;
            dwell_d = '0;
            sel_d   = 2'd0;
            disp_d  = in_total;
         end
         ST_SCAN: begin
            if (state_q != ST_SCAN) begin
               dwell_d = '0;
               sel_d   = 2'd0;
            end else if (dwell_q == DWELL_LAST) begin
               dwell_d = '0;
               sel_d   = sel_q + 2'd1;
            end else begin
               dwell_d = dwell_q + 16'd1;
            end
            disp_d = snap_q[sel_d];
         end
         ST_CLEAR: begin
            for (int unsigned i = 0; i < 4; i++) begin
               snap_d[i] = '0;
            end
            dwell_d = '0;
            sel_d   = 2'd0;
            disp_d  = '0;
         end
         default: ;
      endcase
   end

   // Requests seen while in (or entering) CLEAR are parked and answered
   // with zero on the first RUN cycle.
   always_comb begin
      ack_d    = 1'b0;
      rddata_d = rddata_q;
      pend_d   = pend_q;
      if (state_d == ST_CLEAR) begin
         pend_d = pend_q | (in_RDREQ & ~ack_q);
      end else if (state_q == ST_CLEAR) begin
         pend_d = 1'b0;
         if (pend_q || in_RDREQ) begin
            ack_d    = 1'b1;
            rddata_d = '0;
         end
      end else if (in_RDREQ && !ack_q) begin
         ack_d    = 1'b1;
         rddata_d = (state_q == ST_RUN) ? live[in_RDSEL] : snap_q[in_RDSEL];
      end
   end

   always_ff @(posedge in_CLK or negedge in_RST) begin
      if (!in_RST) begin
         state_q     <= ST_RUN;
         clr_phase_q <= 1'b0;
         for (int unsigned i = 0; i < 4; i++) begin
            snap_q[i] <= '0;
         end
         dwell_q     <= '0;
         sel_q       <= 2'd0;
         disp_q      <= '0;
         cntrst_q    <= 1'b0;
         pend_q      <= 1'b0;
         ack_q       <= 1'b0;
         rddata_q    <= '0;
      end else begin
         state_q     <= state_d;
         clr_phase_q <= clr_phase_d;
         snap_q      <= snap_d;
         dwell_q     <= dwell_d;
         sel_q       <= sel_d;
         disp_q      <= disp_d;
         cntrst_q    <= cntrst_d;
         pend_q      <= pend_d;
         ack_q       <= ack_d;
         rddata_q    <= rddata_d;
      end
   end

   assign out_STATE   = state_q;
   assign out_DISP    = disp_q;
   assign out_DISPSEL = sel_q;
   assign out_CNTRST  = cntrst_q;
   assign out_RDACK   = ack_q;
   assign out_RDDATA  = rddata_q;

endmodule

// File: tb/tb_stat_sched.sv
// Self-checking bench for stat_sched: randomized counter values against an
// expectation model built from the scan/read/clear rules.
module tb_stat_sched;
   localparam int unsigned DW = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        halt = 1'b0;
   logic        clrreq = 1'b0;
   logic [31:0] lv [4];
   logic [31:0] disp;
   logic [1:0]  dispsel;
   logic        cntrst;
   logic [1:0]  state;

   int n_run = 0;
   int n_fail = 0;

   stat_sched_if rd_if ();

   stat_sched #(.DWELL(DW)) dut (
      .in_CLK      (clk),
      .in_RST      (rst_n),
      .in_HALT     (halt),
      .in_CLRREQ   (clrreq),
      .in_total    (lv[0]),
      .in_J        (lv[1]),
      .in_JS       (lv[2]),
      .in_loaduse  (lv[3]),
      .in_RDREQ    (rd_if.in_RDREQ),
      .in_RDSEL    (rd_if.in_RDSEL),
      .out_RDACK   (rd_if.out_RDACK),
      .out_RDDATA  (rd_if.out_RDDATA),
      .out_DISP    (disp),
      .out_DISPSEL (dispsel),
      .out_CNTRST  (cntrst),
      .out_STATE   (state)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic scramble_live;
      for (int i = 0; i < 4; i++) lv[i] = $urandom | 32'h1;
   endtask

   task automatic test_reset;
      scramble_live();
      halt = 1'b1; clrreq = 1'b1;
      rd_if.in_RDREQ = 1'b1; rd_if.in_RDSEL = 2'd3;
      #2 rst_n = 1'b0;
      #1;
      n_run++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
      n_run++; if ({disp, dispsel, cntrst} !== 35'd0) begin n_fail++; $display("FAIL reset_disp: disp %0h sel %0d cntrst %0b want 0", disp, dispsel, cntrst); end
      n_run++; if ({rd_if.out_RDACK, rd_if.out_RDDATA} !== 33'd0) begin n_fail++; $display("FAIL reset_rd: ack %0b data %0h want 0", rd_if.out_RDACK, rd_if.out_RDDATA); end
      halt = 1'b0; clrreq = 1'b0; rd_if.in_RDREQ = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_run;
      for (int i = 0; i < 6; i++) begin
         logic [31:0] exp_total;
         scramble_live();
         exp_total = lv[0];
         tick();
         n_run++; if (state !== 2'd0 || dispsel !== 2'd0) begin n_fail++; $display("FAIL run_state: state %0d sel %0d want 0/0", state, dispsel); end
         n_run++; if (disp !== exp_total) begin n_fail++; $display("FAIL run_disp: got %0h want %0h", disp, exp_total); end
      end
   endtask

   task automatic test_scan(input logic [31:0] v0, input logic [31:0] v1,
                            input logic [31:0] v2, input logic [31:0] v3);
      logic [31:0] snap [4];
      lv[0] = v0; lv[1] = v1; lv[2] = v2; lv[3] = v3;
      halt = 1'b1;
      tick();
      n_run++; if (state !== 2'd1 || disp !== v0) begin n_fail++; $display("FAIL snap_entry: state %0d disp %0h want 1/%0h", state, disp, v0); end
      snap = lv;
      scramble_live();
      for (int n = 0; n < int'(5 * DW); n++) begin
         int exp_sel;
         tick();
         exp_sel = (n / int'(DW)) % 4;
         n_run++; if (state !== 2'd2 || dispsel !== exp_sel[1:0]) begin n_fail++; $display("FAIL scan_sel n=%0d: state %0d sel %0d want 2/%0d", n, state, dispsel, exp_sel); end
         n_run++; if (disp !== snap[exp_sel]) begin n_fail++; $display("FAIL scan_disp n=%0d: got %0h want %0h", n, disp, snap[exp_sel]); end
         scramble_live();
      end
   endtask

   task automatic test_scan_exit;
      logic [31:0] exp_total;
      halt = 1'b0;
      scramble_live();
      exp_total = lv[0];
      tick();
      n_run++; if (state !== 2'd0 || dispsel !== 2'd0 || disp !== exp_total) begin n_fail++; $display("FAIL scan_exit: state %0d sel %0d disp %0h want 0/0/%0h", state, dispsel, disp, exp_total); end
   endtask

   task automatic test_read_run;
      for (int i = 0; i < 6; i++) begin
         logic [31:0] exp_data;
         logic [1:0]  s;
         scramble_live();
         s = 2'($urandom_range(0, 3));
         exp_data = lv[s];
         rd_if.in_RDREQ = 1'b1; rd_if.in_RDSEL = s;
         tick();
         rd_if.in_RDREQ = 1'b0;
         n_run++; if (rd_if.out_RDACK !== 1'b1 || rd_if.out_RDDATA !== exp_data) begin n_fail++; $display("FAIL read_run sel=%0d: ack %0b data %0h want 1/%0h", s, rd_if.out_RDACK, rd_if.out_RDDATA, exp_data); end
         scramble_live();
         tick();
         n_run++; if (rd_if.out_RDACK !== 1'b0 || rd_if.out_RDDATA !== exp_data) begin n_fail++; $display("FAIL read_hold: ack %0b data %0h want 0/%0h", rd_if.out_RDACK, rd_if.out_RDDATA, exp_data); end
      end
   endtask

   task automatic test_read_scan;
      logic [31:0] snap [4];
      logic [1:0]  s;
      scramble_live();
      snap = lv;
      halt = 1'b1;
      tick();
      scramble_live();
      tick();
      s = 2'($urandom_range(0, 3));
      rd_if.in_RDREQ = 1'b1; rd_if.in_RDSEL = s;
      for (int k = 0; k < 4; k++) begin
         logic exp_ack;
         tick();
         exp_ack = (k % 2 == 0);
         n_run++; if (rd_if.out_RDACK !== exp_ack || rd_if.out_RDDATA !== snap[s]) begin n_fail++; $display("FAIL read_scan k=%0d sel=%0d: ack %0b data %0h want %0b/%0h", k, s, rd_if.out_RDACK, rd_if.out_RDDATA, exp_ack, snap[s]); end
         scramble_live();
      end
      rd_if.in_RDREQ = 1'b0;
      halt = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back;
      logic        exp_ack = 1'b0;
      logic [31:0] exp_data = rd_if.out_RDDATA;
      halt = 1'b0;
      for (int t = 0; t < 40; t++) begin
         logic req;
         logic [1:0] s;
         scramble_live();
         req = ($urandom_range(0, 3) != 0);
         s = 2'($urandom_range(0, 3));
         rd_if.in_RDREQ = req; rd_if.in_RDSEL = s;
         exp_ack = req && !exp_ack;
         if (exp_ack) exp_data = lv[s];
         tick();
         n_run++; if (rd_if.out_RDACK !== exp_ack || rd_if.out_RDDATA !== exp_data) begin n_fail++; $display("FAIL b2b t=%0d: ack %0b data %0h want %0b/%0h", t, rd_if.out_RDACK, rd_if.out_RDDATA, exp_ack, exp_data); end
      end
      rd_if.in_RDREQ = 1'b0;
      tick();
   endtask

   task automatic test_clear;
      int hi = 0;
      scramble_live();
      clrreq = 1'b1; halt = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick();
         if (cntrst === 1'b1) begin
            hi++;
            for (int i = 0; i < 4; i++) lv[i] = '0;
         end
         n_run++; if (state !== 2'd3 || disp !== 32'd0 || dispsel !== 2'd0) begin n_fail++; $display("FAIL clear_state c=%0d: state %0d disp %0h sel %0d want 3/0/0", c, state, disp, dispsel); end
      end
      tick();
      if (cntrst === 1'b1) hi++;
      clrreq = 1'b0; halt = 1'b0;
      n_run++; if (state !== 2'd0 || disp !== 32'd0) begin n_fail++; $display("FAIL clear_exit: state %0d disp %0h want 0/0", state, disp); end
      n_run++; if (hi !== 2) begin n_fail++; $display("FAIL clear_cntrst_len: got %0d want 2", hi); end
      tick();
      n_run++; if (state !== 2'd0 || cntrst !== 1'b0) begin n_fail++; $display("FAIL clear_settle: state %0d cntrst %0b want 0/0", state, cntrst); end
   endtask

   task automatic test_clear_from_scan;
      scramble_live();
      halt = 1'b1;
      tick(); tick(); tick();
      clrreq = 1'b1;
      tick();
      clrreq = 1'b0;
      n_run++; if (state !== 2'd3 || cntrst !== 1'b1 || disp !== 32'd0 || dispsel !== 2'd0) begin n_fail++; $display("FAIL clear_from_scan: state %0d cntrst %0b disp %0h sel %0d want 3/1/0/0", state, cntrst, disp, dispsel); end
      halt = 1'b0;
      for (int i = 0; i < 4; i++) lv[i] = '0;
      tick(); tick();
      n_run++; if (state !== 2'd0) begin n_fail++; $display("FAIL clear_from_scan_exit: state %0d want 0", state); end
   endtask

   task automatic test_read_clear;
      scramble_live();
      clrreq = 1'b1;
      tick();
      clrreq = 1'b0;
      for (int i = 0; i < 4; i++) lv[i] = '0;
      rd_if.in_RDREQ = 1'b1; rd_if.in_RDSEL = 2'($urandom_range(0, 3));
      tick();
      rd_if.in_RDREQ = 1'b0;
      n_run++; if (rd_if.out_RDACK !== 1'b0 || state !== 2'd3) begin n_fail++; $display("FAIL read_clear_hold: ack %0b state %0d want 0/3", rd_if.out_RDACK, state); end
      scramble_live();
      tick();
      n_run++; if (state !== 2'd0 || rd_if.out_RDACK !== 1'b1 || rd_if.out_RDDATA !== 32'd0) begin n_fail++; $display("FAIL read_clear_ack: state %0d ack %0b data %0h want 0/1/0", state, rd_if.out_RDACK, rd_if.out_RDDATA); end
      tick();
      n_run++; if (rd_if.out_RDACK !== 1'b0 || rd_if.out_RDDATA !== 32'd0) begin n_fail++; $display("FAIL read_clear_after: ack %0b data %0h want 0/0", rd_if.out_RDACK, rd_if.out_RDDATA); end
   endtask

   task automatic test_reset_clear;
      clrreq = 1'b1;
      tick();
      clrreq = 1'b0;
      tick();
      n_run++; if (cntrst !== 1'b1 || state !== 2'd3) begin n_fail++; $display("FAIL rstclr_pre: cntrst %0b state %0d want 1/3", cntrst, state); end
      #2 rst_n = 1'b0;
      #1;
      n_run++; if (cntrst !== 1'b0 || state !== 2'd0) begin n_fail++; $display("FAIL rstclr_async: cntrst %0b state %0d want 0/0", cntrst, state); end
      #2 rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_run++; if (cntrst !== 1'b0 || state !== 2'd0) begin n_fail++; $display("FAIL rstclr_after c=%0d: cntrst %0b state %0d want 0/0", c, cntrst, state); end
      end
   endtask

   task automatic test_async_reset;
      scramble_live();
      halt = 1'b1;
      tick(); tick(); tick();
      rd_if.in_RDREQ = 1'b1; rd_if.in_RDSEL = 2'd1;
      tick();
      n_run++; if (rd_if.out_RDACK !== 1'b1 || state !== 2'd2) begin n_fail++; $display("FAIL areset_pre: ack %0b state %0d want 1/2", rd_if.out_RDACK, state); end
      clrreq = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      n_run++; if ({state, disp, dispsel, cntrst, rd_if.out_RDACK, rd_if.out_RDDATA} !== 70'd0) begin n_fail++; $display("FAIL areset_outputs: state %0d disp %0h sel %0d cntrst %0b ack %0b data %0h want all 0", state, disp, dispsel, cntrst, rd_if.out_RDACK, rd_if.out_RDDATA); end
      clrreq = 1'b0; halt = 1'b0; rd_if.in_RDREQ = 1'b0;
      #1 rst_n = 1'b1;
      tick();
      n_run++; if (state !== 2'd0 || disp !== lv[0]) begin n_fail++; $display("FAIL areset_resume: state %0d disp %0h want 0/%0h", state, disp, lv[0]); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rd_if.in_RDREQ = 1'b0;
      rd_if.in_RDSEL = 2'd0;
      for (int i = 0; i < 4; i++) lv[i] = '0;
      test_reset();
      test_run();
      test_scan(32'd100, 32'd7, 32'd3, 32'd2);
      test_scan_exit();
      test_scan($urandom, $urandom, $urandom, $urandom);
      test_scan_exit();
      test_read_run();
      test_read_scan();
      test_back_to_back();
      test_clear();
      test_clear_from_scan();
      test_read_clear();
      test_reset_clear();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
